alarm_timer_bank: RTL

//  Parametrised store of N programmable alarm timing intervals plus an integrated countdown timer.
//  The alarm FSM selects an interval, pulses start, and receives a one-cycle expired pulse after that many ticks.

---
 rtl/alarm_timer_pkg.sv | 25 ++
 rtl/alarm_countdown.sv | 100 ++++++++++
 rtl/alarm_timer_bank.sv | 75 +++++++
 3 files changed

// File: rtl/alarm_timer_pkg.sv
// Shared definitions for the alarm timer bank: countdown FSM encoding,
// symbolic interval indices and the reset values of the interval store.
package alarm_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_EXPIRED = 2'd2
    } timer_state_t;

    localparam int IDX_ARM_DELAY       = 0;
    localparam int IDX_DRIVER_DELAY    = 1;
    localparam int IDX_PASSENGER_DELAY = 2;
    localparam int IDX_ALARM_ON        = 3;

    localparam logic [3:0] DEF_ARM_DELAY       = 4'h6;
    localparam logic [3:0] DEF_DRIVER_DELAY    = 4'h8;
    localparam logic [3:0] DEF_PASSENGER_DELAY = 4'hF;
    localparam logic [3:0] DEF_ALARM_ON        = 4'hA;

    // Packed reset image of the store, index 0 in the LSBs.
    localparam logic [15:0] DEFAULT_INTERVALS = {DEF_ALARM_ON, DEF_PASSENGER_DELAY,
                                                 DEF_DRIVER_DELAY, DEF_ARM_DELAY};

endpackage

// File: rtl/alarm_countdown.sv
// Countdown engine for the alarm timer bank: FSM, remaining-ticks counter and,
// when TIMER_PRESCALE_EN is defined, an internal tick prescaler (the tick
// port is then ignored and DIV_CYCLES sets the tick period).
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_IDLE    | no count in progress, remaining holds 0 or the last value
//  ST_COUNT   | counting down one per tick, busy asserted
//  ST_EXPIRED | count reached zero; expired asserted for this one cycle
module alarm_countdown
    import alarm_timer_pkg::*;
#(
    parameter int VAL_W = 4
`ifdef TIMER_PRESCALE_EN
    , parameter int DIV_CYCLES = 50_000_000
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             cancel,
    input  logic             tick,
    input  logic [VAL_W-1:0] load_value,
    output logic [VAL_W-1:0] remaining,
    output logic             busy,
    output logic             expired
);

    timer_state_t state;
    timer_state_t state_next;
    logic         tick_en;

`ifdef TIMER_PRESCALE_EN
    localparam int              PRE_W    = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV_CYCLES - 1);

    logic [PRE_W-1:0] pre_cnt;

    // Prescaler down-counter; reloads on start so the first tick lands DIV_CYCLES cycles later.
    always_ff @(posedge clock) begin
        if (reset || start) begin
            pre_cnt <= PRE_LAST;
        end else if (pre_cnt == '0) begin
            pre_cnt <= PRE_LAST;
        end else begin
            pre_cnt <= pre_cnt - 1'b1;
        end
    end

    assign tick_en = (pre_cnt == '0);
`else
    assign tick_en = tick;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: cancel beats start, start beats tick.
    always_comb begin
        state_next = state;
        if (cancel) begin
            state_next = ST_IDLE;
        end else if (start) begin
            state_next = (load_value == '0) ? ST_EXPIRED : ST_COUNT;
        end else begin
            case (state)
                ST_IDLE:    state_next = ST_IDLE;
                ST_COUNT:   if (tick_en && remaining <= VAL_W'(1)) state_next = ST_EXPIRED;
                ST_EXPIRED: state_next = ST_IDLE;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    // Remaining-ticks down-counter; saturates at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            remaining <= '0;
        end else if (cancel) begin
            remaining <= '0;
        end else if (start) begin
            remaining <= load_value;
        end else if (state == ST_COUNT && tick_en && remaining != '0) begin
            remaining <= remaining - 1'b1;
        end
    end

    // Moore outputs decoded from the state.
    always_comb begin
        busy    = (state == ST_COUNT);
        expired = (state == ST_EXPIRED);
    end

endmodule

// File: rtl/alarm_timer_bank.sv
// Alarm timer bank: N_PARAMS run-time programmable intervals with a
// combinational read port, feeding an integrated countdown timer.
// Optional build macro TIMER_PRESCALE_EN: derive the tick internally from
// DIV_CYCLES clock cycles instead of using the tick port.
module alarm_timer_bank
    import alarm_timer_pkg::*;
#(
    parameter int                          VAL_W    = 4,
    parameter int                          N_PARAMS = 4,
    parameter int                          SEL_W    = $clog2(N_PARAMS),
    parameter logic [N_PARAMS*VAL_W-1:0]   DEFAULTS = DEFAULT_INTERVALS
`ifdef TIMER_PRESCALE_EN
    , parameter int                        DIV_CYCLES = 50_000_000
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             reprogram,
    input  logic [SEL_W-1:0] time_param_sel,
    input  logic [VAL_W-1:0] time_value,
    input  logic [SEL_W-1:0] interval,
    input  logic             start,
    input  logic             cancel,
    input  logic             tick,
    output logic [VAL_W-1:0] value,
    output logic [VAL_W-1:0] remaining,
    output logic             busy,
    output logic             expired
);

    logic [VAL_W-1:0] store [N_PARAMS];

    // Interval store write; per-entry decode so out-of-range selects hit nothing.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_PARAMS; i++) begin
                store[i] <= DEFAULTS[i*VAL_W +: VAL_W];
            end
        end else if (reprogram) begin
            for (int i = 0; i < N_PARAMS; i++) begin
                if (time_param_sel == SEL_W'(i)) begin
                    store[i] <= time_value;
                end
            end
        end
    end

    // Read mux; a start reads this pre-write value, so same-cycle reprogram loads the old entry.
    always_comb begin
        value = '0;
        for (int i = 0; i < N_PARAMS; i++) begin
            if (interval == SEL_W'(i)) begin
                value = store[i];
            end
        end
    end

    alarm_countdown #(
        .VAL_W      (VAL_W)
`ifdef TIMER_PRESCALE_EN
        , .DIV_CYCLES (DIV_CYCLES)
`endif
    ) u_countdown (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .cancel     (cancel),
        .tick       (tick),
        .load_value (value),
        .remaining  (remaining),
        .busy       (busy),
        .expired    (expired)
    );

endmodule
